// File: rtl/mem_arbiter_if.sv
// Bundle for the fetch, load/store and shared memory ports of mem_arbiter.
// master is the arbiter view; slave is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rsp;
  logic [DATA_W-1:0] if_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_rsp;
  logic [DATA_W-1:0]   d_rdata;

  logic rsp_err;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_ready;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rsp, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rsp, d_rdata,
    output rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rsp, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rsp, d_rdata,
    input  rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store.
// One transaction in flight; data has priority with a fetch starvation guard.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int         BE_W = DATA_W / 8;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [7:0] TMAX = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [3:0]        starve_q, starve_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              if_rsp_q, if_rsp_d;
  logic              d_rsp_q, d_rsp_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic arb_en;
  logic if_win;
  logic d_win;
  logic if_gnt;
  logic d_gnt;

  // The cycle carrying a response is spent idle so gnt never meets rsp.
  assign arb_en = (state_q == IDLE) && !rst &&
                  !if_rsp_q && !d_rsp_q;
  assign if_win = bus.if_req &&
                  (!bus.d_req || (starve_q == SMAX));
  assign d_win  = bus.d_req && !if_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    if_rsp_d    = 1'b0;
    d_rsp_d     = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_en) begin
          unique case (1'b1)
            if_win: begin
              if_gnt      = 1'b1;
              owner_d     = 1'b0;
              mem_we_d    = 1'b0;
              mem_addr_d  = bus.if_addr;
              mem_wdata_d = '0;
              mem_be_d    = '1;
              starve_d    = '0;
              mem_req_d   = 1'b1;
              state_d     = ISSUE;
            end
            d_win: begin
              d_gnt       = 1'b1;
              owner_d     = 1'b1;
              mem_we_d    = bus.d_we;
              mem_addr_d  = bus.d_addr;
              mem_wdata_d = bus.d_wdata;
              mem_be_d    = bus.d_be;
              mem_req_d   = 1'b1;
              state_d     = ISSUE;
              if (bus.if_req && (starve_q != SMAX))
                starve_d = starve_q + 4'd1;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            d_rsp_d = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d   = '0;
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (bus.mem_rvalid || (tmo_q == TMAX)) begin
          err_d   = !bus.mem_rvalid;
          state_d = IDLE;
          if (owner_q) begin
            d_rsp_d   = 1'b1;
            d_rdata_d = bus.mem_rvalid ? bus.mem_rdata : '0;
          end else begin
            if_rsp_d   = 1'b1;
            if_rdata_d = bus.mem_rvalid ? bus.mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      starve_q    <= '0;
      tmo_q       <= '0;
      if_rsp_q    <= 1'b0;
      d_rsp_q     <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      if_rsp_q    <= if_rsp_d;
      d_rsp_q     <= d_rsp_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_rsp    = if_rsp_q;
  assign bus.d_rsp     = d_rsp_q;
  assign bus.rsp_err   = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected
// grants, memory accesses and responses; one monitor checks them.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .STARVE_MAX(4),
    .TIMEOUT   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit who;
    int cyc;
  } gnt_t;

  typedef struct {
    bit          who;
    int          cyc;
    bit          chk_d;
    logic [31:0] rdata;
    bit          err;
  } rsp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    bit          chk_w;
  } mem_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  mem_t mem_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // memory responder
  int          cfg_wait   = 0;
  int          cfg_rv_lat = 1;
  logic [31:0] cfg_rdata  = '0;
  bit          late_rv    = 1'b0;
  int          wait_left  = 0;
  int          rv_cnt     = 0;

  initial begin
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = cfg_rdata;
        end
      end
      if (late_rv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
        late_rv        = 1'b0;
      end
      if (bus.mem_req !== 1'b1) begin
        wait_left = cfg_wait;
      end else if (wait_left > 0) begin
        wait_left--;
      end else begin
        bus.mem_ready = 1'b1;
        if (!bus.mem_we && cfg_rv_lat > 0) rv_cnt = cfg_rv_lat;
      end
    end
  end

  // monitor: grants, memory accesses, responses
  gnt_t ge;
  rsp_t re;
  mem_t me;
  int   run = 0;

  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      if (bus.if_gnt || bus.d_gnt) begin
        chk("gnt_excl", {bus.if_gnt, bus.d_gnt} == 2'b11, 0);
        if (gnt_q.size() == 0) begin
          chk("gnt_unexp", {bus.if_gnt, bus.d_gnt}, 0);
        end else begin
          ge = gnt_q.pop_front();
          chk("gnt_who", bus.d_gnt, ge.who);
          if (ge.cyc >= 0) chk("gnt_cyc", cyc, ge.cyc);
        end
      end
      if (bus.mem_req) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexp", bus.mem_req, 0);
        end else begin
          me = mem_q[0];
          run++;
          chk("mem_we", bus.mem_we, me.we);
          chk("mem_addr", bus.mem_addr, me.addr);
          chk("mem_be", bus.mem_be, me.be);
          if (me.chk_w) chk("mem_wdata", bus.mem_wdata, me.wdata);
          if (bus.mem_ready) begin
            chk("mem_hold", run, me.hold);
            me  = mem_q.pop_front();
            run = 0;
          end
        end
      end
      if (bus.if_rsp || bus.d_rsp) begin
        chk("rsp_excl", {bus.if_rsp, bus.d_rsp} == 2'b11, 0);
        if (rsp_q.size() == 0) begin
          chk("rsp_unexp", {bus.if_rsp, bus.d_rsp}, 0);
        end else begin
          re = rsp_q.pop_front();
          chk("rsp_who", bus.d_rsp, re.who);
          if (re.cyc >= 0) chk("rsp_cyc", cyc, re.cyc);
          chk("rsp_err", bus.rsp_err, re.err);
          if (re.chk_d)
            chk("rsp_data", re.who ? bus.d_rdata : bus.if_rdata,
                re.rdata);
        end
      end
    end
  end

  function automatic void chk_reset_outs();
    chk("rst_if_gnt", bus.if_gnt, 0);
    chk("rst_d_gnt", bus.d_gnt, 0);
    chk("rst_if_rsp", bus.if_rsp, 0);
    chk("rst_d_rsp", bus.d_rsp, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
  endfunction

  // One request from cycle T; gnt expected at T, rsp at T+rsp_lat.
  task automatic issue(input bit who, input bit we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       input int rsp_lat, input bit chk_d,
                       input logic [31:0] rdata, input bit err);
    int t;
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    t = cyc;
    gnt_q.push_back('{who: who, cyc: t});
    mem_q.push_back('{we: we, addr: addr, wdata: wdata,
                      be: who ? be : 4'hF, hold: hold, chk_w: we});
    if (rsp_lat >= 0)
      rsp_q.push_back('{who: who, cyc: t + rsp_lat, chk_d: chk_d,
                        rdata: rdata, err: err});
    if (who) begin
      bus.d_req   = 1'b1;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_be    = be;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (who ? bus.d_gnt : bus.if_gnt) begin
        got = 1'b1;
        break;
      end
    end
    chk("gnt_seen", got, 1);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (rsp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("drain", rsp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int n;
    rst         = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs();

    // lone fetch
    cfg_wait = 0; cfg_rv_lat = 1; cfg_rdata = 32'hDEAD_BEEF;
    issue(0, 0, 32'h10, 0, 4'hF, 1, 3, 1, 32'hDEAD_BEEF, 0);
    drain(20);

    // lone store with two stall cycles
    cfg_wait = 2;
    issue(1, 1, 32'h40, 32'h1234_5678, 4'b0011, 3, 4, 0, 0, 0);
    drain(20);

    // load, data three cycles after acceptance
    cfg_wait = 0; cfg_rv_lat = 3; cfg_rdata = 32'hCAFE_F00D;
    issue(1, 0, 32'h44, 0, 4'hF, 1, 5, 1, 32'hCAFE_F00D, 0);
    drain(20);

    // load timeout, then a stray rvalid in IDLE
    cfg_rv_lat = -1;
    issue(1, 0, 32'h80, 0, 4'hF, 1, 19, 1, 32'h0, 1);
    drain(60);
    late_rv = 1'b1;
    repeat (4) @(negedge clk);
    chk("late_rv_d_rdata", bus.d_rdata, 0);
    chk("late_rv_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);

    // both requesters held: D,D,D,D,F,D,D,D,D,F
    cfg_rv_lat = 1; cfg_rdata = 32'h1111_0000;
    for (int i = 0; i < 10; i++) begin
      bit f;
      f = (i == 4) || (i == 9);
      gnt_q.push_back('{who: !f, cyc: -1});
      mem_q.push_back('{we: !f, addr: f ? 32'h100 : 32'h200,
                        wdata: 32'hA5A5_A5A5, be: 4'hF, hold: 1,
                        chk_w: !f});
      rsp_q.push_back('{who: !f, cyc: -1, chk_d: f,
                        rdata: 32'h1111_0000, err: 0});
    end
    @(posedge clk);
    #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h200;
    bus.d_wdata = 32'hA5A5_A5A5;
    bus.d_be    = 4'hF;
    g = 0;
    n = 0;
    while (g < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.if_gnt || bus.d_gnt) g++;
    end
    chk("arb_gnts", g, 10);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    drain(40);

    // reset during WAIT_R of a fetch abandons it
    cfg_rv_lat = -1;
    issue(0, 0, 32'h20, 0, 4'hF, 1, -1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs();
    repeat (25) @(negedge clk);
    chk("post_rst_if_rdata", bus.if_rdata, 0);
    cfg_rv_lat = 1; cfg_rdata = 32'h0BAD_F00D;
    issue(0, 0, 32'h24, 0, 4'hF, 1, 3, 1, 32'h0BAD_F00D, 0);
    drain(20);

    // short d_req while a fetch sits in ISSUE is dropped
    cfg_wait = 3; cfg_rdata = 32'h7777_8888;
    issue(0, 0, 32'h28, 0, 4'hF, 4, 6, 1, 32'h7777_8888, 0);
    @(posedge clk);
    #1;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h300;
    bus.d_wdata = 32'h5555_AAAA;
    bus.d_be    = 4'hF;
    @(negedge clk);
    chk("drop_no_gnt", bus.d_gnt, 0);
    @(posedge clk);
    #1 bus.d_req = 1'b0;
    drain(20);
    repeat (5) @(negedge clk);

    chk("gnt_q_empty", gnt_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares a single unified memory port between the CPU instruction-fetch path and the load/store path, replacing the separate instruction and data memories of the single-cycle core. It accepts one request per transaction, drives it onto the shared memory port, and returns read data or write completion to the owning requester. It sits between the CPU front end and load/store unit and the memory block.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending (1..15)
- TIMEOUT, 16, max cycles waiting for read data before error response (2..255)

- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; one clock; synchronous, active-high
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request captured
- if_rsp  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word, held until next if_rsp
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  one-cycle pulse: data request captured
- d_rsp  out  1  one-cycle pulse: load data valid or store complete
- d_rdata  out  DATA_W  load data, held until next d_rsp
- rsp_err  out  1  qualifies if_rsp/d_rsp: read timed out, rdata = 0
- mem_req  out  1  request to memory
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
- mem_ready  in  1  memory accepts request this cycle when mem_req=1
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data

## Operation
- One transaction outstanding at a time. FSM states: IDLE, ISSUE, WAIT_R.
- IDLE: arbitrate among asserted requests. Data wins over fetch, except when if_req=1 and starve counter == STARVE_MAX, in which case fetch wins. Winner's fields and an owner bit are captured into registers; the winner's gnt pulses in the same cycle (combinational from state and requests); next state ISSUE. Fetch captures mem_we=0 and mem_be all ones.
- Starve counter: increments (saturating at STARVE_MAX) on each data grant with if_req=1; clears on each fetch grant; unchanged otherwise.
- ISSUE: mem_req=1 with the registered fields. Hold until mem_ready=1. Store accepted: pulse d_rsp next cycle, rsp_err=0, go IDLE. Load or fetch accepted: clear timeout counter, go WAIT_R.
- WAIT_R: mem_req=0. On mem_rvalid: register mem_rdata into the owner's rdata, pulse owner's rsp next cycle with rsp_err=0, go IDLE. If the timeout counter reaches TIMEOUT first: owner's rdata=0, rsp with rsp_err=1, go IDLE. A mem_rvalid arriving in the same cycle as timeout counts as valid.
- mem_rvalid in IDLE or ISSUE is ignored.
- Requests that deassert before gnt are dropped silently. Fields are sampled only on the gnt cycle.
- Reset during any state abandons the transaction: no rsp is issued and no mem_req occurs after reset.

## Timing
- Reset values: state IDLE; mem_req, mem_we, if_gnt, d_gnt, if_rsp, d_rsp, rsp_err = 0; mem_addr, mem_wdata, mem_be, if_rdata, d_rdata = 0; starve and timeout counters = 0.
- gnt in cycle T (IDLE). mem_req asserts in T+1. If mem_ready=1 at T+1: store rsp at T+2; read waits for mem_rvalid at cycle R ≥ T+2, and rsp is at R+1.
- Earliest next gnt: the cycle after returning to IDLE. Minimum store period is 3 cycles. Minimum read period is 4 cycles.
- rsp and gnt never occur in the same cycle for the same requester. if_gnt and d_gnt are never both high.

## Test plan
- Lone fetch, addr 0x10, mem_ready=1, mem_rvalid 1 cycle after acceptance with 0xDEADBEEF -> if_gnt@T, mem_req@T+1, if_rsp@T+3, if_rdata=0xDEADBEEF, rsp_err=0.
- Lone store, addr 0x40, data 0x12345678, be 0b0011, mem_ready low for 2 cycles -> mem_req held 3 cycles with stable fields; d_rsp one cycle after acceptance.
- if_req and d_req held continuously, with STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; counter clears after each F.
- Load with mem_rvalid never asserted, TIMEOUT=16 -> d_rsp with rsp_err=1 and d_rdata=0, 17 cycles after WAIT_R entry; a late mem_rvalid in IDLE is ignored.
- rst pulsed during WAIT_R of a fetch -> no if_rsp, all outputs at reset values next cycle, and the next request is serviced normally.
- d_req raised for one cycle while FSM in ISSUE, then dropped -> no d_gnt and no memory access for it.
